// File: rtl/pcpi_dispatch.sv
// PCPI front end for the M/custom coprocessor: decode and claim core requests,
// issue one request at a time, return the result, and watch for hung completions.
module pcpi_dispatch #(
    parameter logic [6:0] M_OPCODE       = 7'b0110011,
    parameter logic [6:0] M_FUNCT7       = 7'b0000001,
    parameter logic [6:0] CUSTOM_OPCODE  = 7'b0001011,
    parameter logic [7:0] CUSTOM_F3_MASK = 8'b00000011,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic        cp_valid,
    output logic [31:0] cp_insn,
    output logic [31:0] cp_rs1,
    output logic [31:0] cp_rs2,
    input  logic        cp_ready,
    input  logic        cp_wr,
    input  logic        cp_busy,
    input  logic [31:0] cp_rd,
    input  logic        err_clr,
    output logic        err_timeout,
    output logic        err_protocol
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_DISCARD, S_RESP, S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_to_q, err_to_d, err_pr_q, err_pr_d;
    logic          to_set, pr_set, claim;

    // Busy is informational only; completion is signalled solely by cp_ready.
    logic unused_busy;
    assign unused_busy = cp_busy;

    wire [6:0] opcode = pcpi_insn[6:0];
    wire [2:0] funct3 = pcpi_insn[14:12];
    wire [6:0] funct7 = pcpi_insn[31:25];

    assign claim = pcpi_valid &&
                   ((opcode == M_OPCODE && funct7 == M_FUNCT7) ||
                    (opcode == CUSTOM_OPCODE && CUSTOM_F3_MASK[funct3]));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            insn_q   <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            wr_q     <= 1'b0;
            cnt_q    <= '0;
            err_to_q <= 1'b0;
            err_pr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            insn_q   <= insn_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            err_to_q <= err_to_d;
            err_pr_q <= err_pr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        insn_d     = insn_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        to_set     = 1'b0;
        pr_set     = 1'b0;
        pcpi_wait  = 1'b0;
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        pcpi_rd    = '0;
        cp_valid   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Gated by resetn so that every output reads 0 while held in reset.
                pcpi_wait = claim && resetn;
                pr_set    = cp_ready;
                if (claim) begin
                    insn_d  = pcpi_insn;
                    rs1_d   = pcpi_rs1;
                    rs2_d   = pcpi_rs2;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cp_valid  = 1'b1;
                pcpi_wait = 1'b1;
                pr_set    = cp_ready;
                cnt_d     = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                pcpi_wait = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cp_ready) begin
                    if (pcpi_valid) begin
                        rd_d    = cp_rd;
                        wr_d    = cp_wr;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    to_set  = 1'b1;
                    state_d = S_DISCARD;
                end else if (!pcpi_valid) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                // The coprocessor cannot be aborted, so wait out its completion.
                if (cp_ready) state_d = S_DRAIN;
            end
            S_RESP: begin
                pcpi_ready = 1'b1;
                pcpi_wr    = wr_q;
                pcpi_rd    = rd_q;
                pr_set     = cp_ready;
                state_d    = S_DRAIN;
            end
            S_DRAIN: begin
                pr_set  = cp_ready;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        err_to_d = to_set ? 1'b1 : (err_clr ? 1'b0 : err_to_q);
        err_pr_d = pr_set ? 1'b1 : (err_clr ? 1'b0 : err_pr_q);
    end

    assign cp_insn      = insn_q;
    assign cp_rs1       = rs1_q;
    assign cp_rs2       = rs2_q;
    assign err_timeout  = err_to_q;
    assign err_protocol = err_pr_q;

endmodule
